inst_fetch_bridge: RTL
======================

INST_FETCH_BRIDGE -- requirements
Module: inst_fetch_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, meaning the number of REQ-state cycles without mem_ack before abort (range 1..15).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on posedge clk.
REQ-003 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port romen, input, 1, fetch enable from core PC stage.
REQ-005 SHALL have port instaddr, input, 32, fetch address from core.
REQ-006 SHALL have port inst, output, 32, instruction to core IF/ID.
REQ-007 SHALL have port stallreq, output, 1, fetch stall request to stall_ctl, stage-0 slot.
REQ-008 SHALL have port mem_req, output, 1, registered memory read request.
REQ-009 SHALL have port mem_addr, output, 32, registered request address.
REQ-010 SHALL have port mem_rdata, input, 32, memory read data, valid only with mem_ack.
REQ-011 SHALL have port mem_ack, input, 1, one-cycle read completion strobe.
REQ-012 SHALL have port bus_err, output, 1, sticky timeout flag.

Function
REQ-013 SHALL hold a one-entry line: line_valid, line_addr[31:0], line_data[31:0].
REQ-014 SHALL define hit = romen & line_valid & (line_addr == instaddr); miss = romen & ~hit.
REQ-015 SHALL implement FSM states IDLE and REQ only.
REQ-016 In IDLE with miss, SHALL next cycle enter REQ with mem_req=1 and mem_addr=instaddr captured at that edge.
REQ-017 In REQ, SHALL hold mem_req=1 and mem_addr constant until the exit edge.
REQ-018 In REQ with mem_ack=1 at an edge, SHALL load line_addr=mem_addr, line_data=mem_rdata, line_valid=1, drop mem_req, and return to IDLE.
REQ-019 SHALL complete an in-flight request even if instaddr changes or romen drops; the line fills with the captured address, and a new miss is re-detected in IDLE next cycle.
REQ-020 SHALL count REQ cycles in a 4-bit counter cleared on REQ entry.
REQ-021 When the counter reaches TIMEOUT without mem_ack, SHALL set bus_err=1 (sticky until rst), fill the line with mem_addr and NOP 32'h00000013, drop mem_req, and return to IDLE.
REQ-022 If mem_ack arrives on the same edge the counter reaches TIMEOUT, SHALL treat it as a normal completion with no bus_err.
REQ-023 SHALL ignore mem_ack while in IDLE.
REQ-024 SHALL drive stallreq combinationally = miss | (state == REQ).
REQ-025 SHALL drive inst combinationally = line_data when hit, else 32'h0.
REQ-026 With romen=0 in IDLE, SHALL issue no request and drive stallreq=0, inst=0.
REQ-027 Minimum miss latency SHALL be 2 cycles: miss in cycle n, REQ in n+1, ack in n+1, hit in n+2.
REQ-028 Back-to-back distinct addresses SHALL each incur a full miss; there is no prefetch.

Reset
REQ-029 On rst=1 at an edge, SHALL set state=IDLE, line_valid=0, line_addr=0, line_data=0, counter=0, mem_req=0, mem_addr=0, bus_err=0.
REQ-030 SHALL abort any in-flight request on reset; a later mem_ack is ignored.
REQ-031 Outputs after reset with romen=0 SHALL be inst=0, stallreq=0.

Verification
REQ-032 Cold miss: romen=1, instaddr=0x0, mem_ack with rdata=0x00500093 one cycle after mem_req -> stallreq high 2 cycles, then inst=0x00500093 and stallreq=0.
REQ-033 Slow memory: ack after 5 REQ cycles -> mem_req and mem_addr stable all 5 cycles; stallreq high for 6 cycles total; no bus_err.
REQ-034 Redirect mid-request: instaddr changes 0x4->0x20 while in REQ -> line fills 0x4, then a new request for 0x20 issues next cycle.
REQ-035 Timeout: no ack for 15 cycles -> bus_err=1, inst=0x00000013 for that address; bus_err stays 1 until rst.
REQ-036 Ack exactly at TIMEOUT -> data delivered, bus_err stays 0.
REQ-037 Reset in REQ, then late mem_ack -> all outputs at reset values; line stays invalid.

Source files
------------

// File: rtl/inst_fetch_bridge.sv
// Instruction fetch bridge: one-entry line buffer in front of a request/ack
// memory port, with a bounded wait that substitutes a NOP on timeout.
module inst_fetch_bridge #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        romen,
  input  logic [31:0] instaddr,
  output logic [31:0] inst,
  output logic        stallreq,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        bus_err
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_REQ  = 1'b1;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [3:0]  TO_LIM   = 4'(TIMEOUT);

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [31:0] data;
  } line_t;

  logic [0:0]  state_q, state_d;
  line_t       line_q, line_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        bus_err_q, bus_err_d;

  logic        hit, miss;
  logic [3:0]  cnt_inc;

  assign hit     = romen & line_q.valid & (line_q.addr == instaddr);
  assign miss    = romen & ~hit;
  assign cnt_inc = cnt_q + 4'd1;

  always_comb begin
    state_d    = state_q;
    line_d     = line_q;
    cnt_d      = cnt_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    bus_err_d  = bus_err_q;
    case (state_q)
      S_IDLE: begin
        if (miss) begin
          state_d    = S_REQ;
          mem_req_d  = 1'b1;
          mem_addr_d = instaddr;
          cnt_d      = 4'd0;
        end
      end
      S_REQ: begin
        // The captured address is always completed, whatever the core does
        // meanwhile; an ack on the final cycle wins over the timeout.
        if (mem_ack) begin
          line_d    = '{valid: 1'b1, addr: mem_addr_q, data: mem_rdata};
          mem_req_d = 1'b0;
          state_d   = S_IDLE;
        end else if (cnt_inc == TO_LIM) begin
          line_d    = '{valid: 1'b1, addr: mem_addr_q, data: NOP_INST};
          bus_err_d = 1'b1;
          mem_req_d = 1'b0;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      line_q     <= '0;
      cnt_q      <= 4'd0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= 32'd0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      line_q     <= line_d;
      cnt_q      <= cnt_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign stallreq = miss | (state_q == S_REQ);
  assign inst     = hit ? line_q.data : 32'h0;
  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign bus_err  = bus_err_q;

endmodule
